// File: rtl/decode_execute_stage.sv
// Elastic decode->execute register with a one-entry skid buffer and synchronous flush.
// Latency 1 cycle; in_ready_o depends only on skid occupancy, so there is no combinational path from out_ready_i.
module decode_execute_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [CTRL_WIDTH-1:0]     ctrl_d_i,
  input  logic [DATA_WIDTH-1:0]     pc_d_i,
  input  logic [DATA_WIDTH-1:0]     rd1_d_i,
  input  logic [DATA_WIDTH-1:0]     rd2_d_i,
  input  logic [DATA_WIDTH-1:0]     src_b_d_i,
  input  logic [DATA_WIDTH-1:0]     imm_ext_d_i,
  input  logic [REG_ADDR_WIDTH-1:0] rd_addr_d_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [CTRL_WIDTH-1:0]     ctrl_e_o,
  output logic [DATA_WIDTH-1:0]     pc_e_o,
  output logic [DATA_WIDTH-1:0]     rd1_e_o,
  output logic [DATA_WIDTH-1:0]     rd2_e_o,
  output logic [DATA_WIDTH-1:0]     src_b_e_o,
  output logic [DATA_WIDTH-1:0]     imm_ext_e_o,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr_e_o,
  output logic [1:0]                occupancy_o
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     src_b;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
  } pay_t;

  logic                  main_vld_q, main_vld_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  pay_t                  main_pay_q, main_pay_d;
  pay_t                  skid_pay_q, skid_pay_d;
  logic [1:0]            occ_q, occ_d;
  pay_t                  in_pay;
  logic                  in_fire, out_fire;

  assign in_pay   = '{pc: pc_d_i, rd1: rd1_d_i, rd2: rd2_d_i, src_b: src_b_d_i,
                      imm_ext: imm_ext_d_i, rd_addr: rd_addr_d_i};
  assign in_fire  = in_valid_i & ~skid_vld_q;
  assign out_fire = main_vld_q & out_ready_i;

  always_comb begin
    main_vld_d  = main_vld_q;
    skid_vld_d  = skid_vld_q;
    main_ctrl_d = main_ctrl_q;
    skid_ctrl_d = skid_ctrl_q;
    main_pay_d  = main_pay_q;
    skid_pay_d  = skid_pay_q;
    if (flush_i) begin
      // Payload is deliberately left alone; only valids and control are squashed.
      main_vld_d  = 1'b0;
      skid_vld_d  = 1'b0;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else if (!main_vld_q) begin
      if (in_fire) begin
        main_vld_d  = 1'b1;
        main_ctrl_d = ctrl_d_i;
        main_pay_d  = in_pay;
      end
    end else if (!skid_vld_q) begin
      if (in_fire && out_fire) begin
        main_ctrl_d = ctrl_d_i;
        main_pay_d  = in_pay;
      end else if (in_fire) begin
        skid_vld_d  = 1'b1;
        skid_ctrl_d = ctrl_d_i;
        skid_pay_d  = in_pay;
      end else if (out_fire) begin
        main_vld_d  = 1'b0;
        main_ctrl_d = '0;
      end
    end else if (out_fire) begin
      main_ctrl_d = skid_ctrl_q;
      main_pay_d  = skid_pay_q;
      skid_vld_d  = 1'b0;
      skid_ctrl_d = '0;
    end
    occ_d = {1'b0, main_vld_d} + {1'b0, skid_vld_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      main_pay_q  <= '0;
      skid_pay_q  <= '0;
      occ_q       <= 2'd0;
    end else begin
      main_vld_q  <= main_vld_d;
      skid_vld_q  <= skid_vld_d;
      main_ctrl_q <= main_ctrl_d;
      skid_ctrl_q <= skid_ctrl_d;
      main_pay_q  <= main_pay_d;
      skid_pay_q  <= skid_pay_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready_o  = ~skid_vld_q;
  assign out_valid_o = main_vld_q;
  assign occupancy_o = occ_q;
  assign ctrl_e_o    = main_ctrl_q;
  assign pc_e_o      = main_pay_q.pc;
  assign rd1_e_o     = main_pay_q.rd1;
  assign rd2_e_o     = main_pay_q.rd2;
  assign src_b_e_o   = main_pay_q.src_b;
  assign imm_ext_e_o = main_pay_q.imm_ext;
  assign rd_addr_e_o = main_pay_q.rd_addr;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Bench for decode_execute_stage: directed vector table, then random traffic against a queue model.
module tb_decode_execute_stage;

  logic        clk = 1'b0;
  logic        rst, flush_i, in_valid_i, out_ready_i;
  logic        in_ready_o, out_valid_o;
  logic [9:0]  ctrl_d_i, ctrl_e_o;
  logic [31:0] pc_d_i, rd1_d_i, rd2_d_i, src_b_d_i, imm_ext_d_i;
  logic [31:0] pc_e_o, rd1_e_o, rd2_e_o, src_b_e_o, imm_ext_e_o;
  logic [4:0]  rd_addr_d_i, rd_addr_e_o;
  logic [1:0]  occupancy_o;

  always #5 clk = ~clk;

  decode_execute_stage dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ctrl_d_i(ctrl_d_i), .pc_d_i(pc_d_i), .rd1_d_i(rd1_d_i), .rd2_d_i(rd2_d_i),
    .src_b_d_i(src_b_d_i), .imm_ext_d_i(imm_ext_d_i), .rd_addr_d_i(rd_addr_d_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .ctrl_e_o(ctrl_e_o), .pc_e_o(pc_e_o), .rd1_e_o(rd1_e_o), .rd2_e_o(rd2_e_o),
    .src_b_e_o(src_b_e_o), .imm_ext_e_o(imm_ext_e_o), .rd_addr_e_o(rd_addr_e_o),
    .occupancy_o(occupancy_o)
  );

  typedef struct packed {
    logic [9:0]  ctrl;
    logic [31:0] pc, rd1, rd2, src_b, imm;
    logic [4:0]  rd_addr;
  } ent_t;

  typedef struct {
    logic rst, flush, iv, ordy;
    logic [31:0] pc;
    logic [9:0]  ctrl;
    logic ov, ir;
    logic [1:0]  occ;
    logic [31:0] epc;
    logic [9:0]  ectrl;
  } vec_t;

  // Reference model: accepted-but-not-retired instructions in order, plus the last head shown.
  ent_t q[$];
  ent_t last_head;
  int   n_pass = 0, n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic ordy, input ent_t e);
    rst = r; flush_i = f; in_valid_i = iv; out_ready_i = ordy;
    ctrl_d_i = e.ctrl; pc_d_i = e.pc; rd1_d_i = e.rd1; rd2_d_i = e.rd2;
    src_b_d_i = e.src_b; imm_ext_d_i = e.imm; rd_addr_d_i = e.rd_addr;
  endtask

  function automatic ent_t from_pc(input logic [31:0] pc, input logic [9:0] ctrl);
    ent_t e;
    e.ctrl = ctrl; e.pc = pc; e.rd1 = pc ^ 32'h1111_0000; e.rd2 = pc + 32'd7;
    e.src_b = ~pc; e.imm = pc << 1; e.rd_addr = pc[6:2];
    return e;
  endfunction

  function automatic vec_t mkv(input logic r, f, iv, ordy, input logic [31:0] pc,
                               input logic [9:0] ctrl, input logic ov, ir,
                               input logic [1:0] occ, input logic [31:0] epc,
                               input logic [9:0] ectrl);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.ordy = ordy; v.pc = pc; v.ctrl = ctrl;
    v.ov = ov; v.ir = ir; v.occ = occ; v.epc = epc; v.ectrl = ectrl;
    return v;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit ofire, ifire;
    ent_t e;
    if (rst) begin
      q.delete();
      last_head = '0;
    end else begin
      ofire = (q.size() > 0) && out_ready_i;
      ifire = in_valid_i && (q.size() < 2);
      e = '{ctrl: ctrl_d_i, pc: pc_d_i, rd1: rd1_d_i, rd2: rd2_d_i,
            src_b: src_b_d_i, imm: imm_ext_d_i, rd_addr: rd_addr_d_i};
      if (flush_i) q.delete();
      else begin
        if (ofire) void'(q.pop_front());
        if (ifire) q.push_back(e);
      end
      if (q.size() > 0) last_head = q[0];
    end
  endtask

  task automatic check_model();
    logic [9:0] ectrl;
    ectrl = (q.size() > 0) ? q[0].ctrl : 10'h0;
    check("rnd_out_valid", 64'(out_valid_o), 64'(q.size() > 0));
    check("rnd_in_ready",  64'(in_ready_o),  64'(q.size() < 2));
    check("rnd_occupancy", 64'(occupancy_o), 64'(q.size()));
    check("rnd_ctrl",      64'(ctrl_e_o),    64'(ectrl));
    check("rnd_pc",        64'(pc_e_o),      64'(last_head.pc));
    check("rnd_rd1",       64'(rd1_e_o),     64'(last_head.rd1));
    check("rnd_rd2",       64'(rd2_e_o),     64'(last_head.rd2));
    check("rnd_src_b",     64'(src_b_e_o),   64'(last_head.src_b));
    check("rnd_imm",       64'(imm_ext_e_o), 64'(last_head.imm));
    check("rnd_rd_addr",   64'(rd_addr_e_o), 64'(last_head.rd_addr));
  endtask

  vec_t tbl[25];

  initial begin
    last_head = '0;
    //              rst f iv rdy pc       ctrl   | ov ir occ pc      ctrl
    tbl[0]  = mkv(1, 0, 0, 0, 32'h00, 10'h000, 0, 1, 0, 32'h00, 10'h000);
    tbl[1]  = mkv(1, 0, 0, 0, 32'h00, 10'h000, 0, 1, 0, 32'h00, 10'h000);
    tbl[2]  = mkv(0, 0, 1, 1, 32'h00, 10'h011, 1, 1, 1, 32'h00, 10'h011);
    tbl[3]  = mkv(0, 0, 1, 1, 32'h04, 10'h012, 1, 1, 1, 32'h04, 10'h012);
    tbl[4]  = mkv(0, 0, 1, 1, 32'h08, 10'h013, 1, 1, 1, 32'h08, 10'h013);
    tbl[5]  = mkv(0, 0, 1, 1, 32'h0C, 10'h014, 1, 1, 1, 32'h0C, 10'h014);
    tbl[6]  = mkv(0, 0, 0, 1, 32'h00, 10'h000, 0, 1, 0, 32'h0C, 10'h000);
    tbl[7]  = mkv(0, 0, 1, 0, 32'h10, 10'h021, 1, 1, 1, 32'h10, 10'h021);
    tbl[8]  = mkv(0, 0, 1, 0, 32'h14, 10'h022, 1, 0, 2, 32'h10, 10'h021);
    tbl[9]  = mkv(0, 0, 1, 0, 32'h18, 10'h023, 1, 0, 2, 32'h10, 10'h021);
    tbl[10] = mkv(0, 0, 1, 1, 32'h18, 10'h023, 1, 1, 1, 32'h14, 10'h022);
    tbl[11] = mkv(0, 0, 1, 1, 32'h18, 10'h023, 1, 1, 1, 32'h18, 10'h023);
    tbl[12] = mkv(0, 0, 0, 1, 32'h00, 10'h000, 0, 1, 0, 32'h18, 10'h000);
    tbl[13] = mkv(0, 0, 1, 0, 32'h20, 10'h031, 1, 1, 1, 32'h20, 10'h031);
    tbl[14] = mkv(0, 0, 1, 0, 32'h24, 10'h032, 1, 0, 2, 32'h20, 10'h031);
    tbl[15] = mkv(0, 1, 0, 0, 32'h00, 10'h000, 0, 1, 0, 32'h20, 10'h000);
    tbl[16] = mkv(0, 0, 1, 0, 32'h40, 10'h041, 1, 1, 1, 32'h40, 10'h041);
    tbl[17] = mkv(0, 0, 0, 1, 32'h00, 10'h000, 0, 1, 0, 32'h40, 10'h000);
    tbl[18] = mkv(0, 1, 1, 1, 32'h50, 10'h3FF, 0, 1, 0, 32'h40, 10'h000);
    tbl[19] = mkv(0, 0, 0, 1, 32'h00, 10'h000, 0, 1, 0, 32'h40, 10'h000);
    tbl[20] = mkv(0, 0, 1, 1, 32'h60, 10'h3FF, 1, 1, 1, 32'h60, 10'h3FF);
    tbl[21] = mkv(0, 0, 0, 1, 32'h00, 10'h000, 0, 1, 0, 32'h60, 10'h000);
    tbl[22] = mkv(0, 0, 1, 0, 32'h70, 10'h051, 1, 1, 1, 32'h70, 10'h051);
    tbl[23] = mkv(0, 0, 1, 0, 32'h74, 10'h052, 1, 0, 2, 32'h70, 10'h051);
    tbl[24] = mkv(1, 1, 1, 0, 32'h78, 10'h053, 0, 1, 0, 32'h00, 10'h000);

    drive(1, 0, 0, 0, '0);
    #1;
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].ordy, from_pc(tbl[i].pc, tbl[i].ctrl));
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid_o), 64'(tbl[i].ov));
      check($sformatf("vec%0d_in_ready", i),  64'(in_ready_o),  64'(tbl[i].ir));
      check($sformatf("vec%0d_occupancy", i), 64'(occupancy_o), 64'(tbl[i].occ));
      check($sformatf("vec%0d_pc", i),        64'(pc_e_o),      64'(tbl[i].epc));
      check($sformatf("vec%0d_ctrl", i),      64'(ctrl_e_o),    64'(tbl[i].ectrl));
      if (tbl[i].rst)
        check($sformatf("vec%0d_rst_payload", i),
              64'({rd1_e_o, rd2_e_o} | {src_b_e_o, imm_ext_e_o} | 64'(rd_addr_e_o)), 64'h0);
    end

    for (int n = 0; n < 3000; n++) begin
      ent_t e;
      e.ctrl = 10'($urandom); e.pc = $urandom; e.rd1 = $urandom; e.rd2 = $urandom;
      e.src_b = $urandom; e.imm = $urandom; e.rd_addr = 5'($urandom);
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6), e);
      @(posedge clk);
      model_step();
      #1;
      check_model();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_execute_stage.md
# decode_execute_stage

Elastic decode-to-execute pipeline stage for the RISC-V core. It registers the decoded control word and operand payload between decode and execute. It adds a valid/ready handshake, a one-entry skid buffer so that execute back-pressure does not create a combinational ready path into decode, and a synchronous flush that squashes in-flight instructions on branch/JALR redirect. Outputs feed the execute stage and the hazard unit.

## Interface

- DATA_WIDTH, 32, width of PC, operands and immediate
- REG_ADDR_WIDTH, 5, width of destination register address
- CTRL_WIDTH, 10, width of packed control word (minimum 10)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush_i  input  1  squash all held entries this cycle
- in_valid_i  input  1  decode presents a valid instruction
- in_ready_o  output  1  stage can accept an instruction this cycle
- ctrl_d_i  input  CTRL_WIDTH  packed control word from decode
- pc_d_i  input  DATA_WIDTH  instruction PC
- rd1_d_i  input  DATA_WIDTH  register-file read data 1
- rd2_d_i  input  DATA_WIDTH  register-file read data 2
- src_b_d_i  input  DATA_WIDTH  selected ALU operand B
- imm_ext_d_i  input  DATA_WIDTH  sign-extended immediate
- rd_addr_d_i  input  REG_ADDR_WIDTH  destination register
- out_valid_o  output  1  execute-side entry valid
- out_ready_i  input  1  execute accepts entry this cycle
- ctrl_e_o, pc_e_o, rd1_e_o, rd2_e_o, src_b_e_o, imm_ext_e_o, rd_addr_e_o  output  (widths as above)  registered payload
- occupancy_o  output  2  number of held entries (0..2)

## Operation

- Control word bit map: [0] reg_write, [1] result_src, [2] mem_write, [3] addr_select, [4] branch_src, [5] jalr, [9:6] alu_ctrl, upper bits are passed through.
- Storage consists of a main register (drives all *_e_o) and a skid register, each with a valid bit.
- in_fire = in_valid_i & in_ready_o. out_fire = out_valid_o & out_ready_i.
- in_ready_o = !skid_valid. It is a function of state only and has no path from out_ready_i.
- States are EMPTY (occupancy 0), HALF (main only, 1) and FULL (main+skid, 2).
- EMPTY:
  - in_fire -> main loads input, go to HALF.
- HALF:
  - in_fire & out_fire -> main loads input, stay in HALF.
  - in_fire only -> skid loads input, go to FULL.
  - out_fire only -> go to EMPTY.
  - Neither -> hold.
- FULL: in_ready_o = 0.
  - out_fire -> main loads skid, skid invalidated, go to HALF.
  - Otherwise hold all values.
- Invariant: ctrl_e_o == 0 whenever out_valid_o == 0. The main ctrl register is cleared on any transition leaving it invalid.
- Data payload (pc, rd1, rd2, src_b, imm_ext, rd_addr) is not cleared on invalidation. It holds its last value.
- Flush (priority below rst, above all handshakes):
  - Both valids are cleared, both ctrl registers are zeroed, and the state becomes EMPTY.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle is still a completed transfer from the execute side's perspective.
- Payload is never reordered or duplicated. Instructions leave in acceptance order.

## Timing

- rst: out_valid_o=0, in_ready_o=1, occupancy_o=0, and all *_e_o = 0 on the cycle after rst is sampled high.
- Latency: an input accepted at edge N appears on *_e_o with out_valid_o=1 after edge N (visible in cycle N+1).
- Throughput is 1 instruction/cycle while out_ready_i stays high.
- One-cycle out_ready_i deassertion: the next input goes to skid and in_ready_o drops the following cycle. No instruction is lost.
- in_ready_o recovers one cycle after the FULL->HALF drain.
- flush_i asserted at edge N: out_valid_o=0 and in_ready_o=1 from cycle N+1. An input offered in cycle N+1 is accepted normally.
- rst asserted mid-operation overrides flush and all handshakes.
- All outputs are driven directly from registers. There is no combinational input-to-output path.

## Test plan

- Reset then stream: rst 2 cycles, then 4 instructions with PC 0x00,0x04,0x08,0x0C and out_ready_i=1 -> out_valid_o high from cycle 2, pc_e_o follows in order one cycle behind input, occupancy_o=1.
- Back-pressure:
  - Stimulus: out_ready_i=0 for 3 cycles while decode offers PC 0x10,0x14,0x18.
  - Required: 0x10 is in main and 0x14 in skid; in_ready_o=0 and 0x18 is held by decode.
  - On release, outputs are 0x10,0x14,0x18 in consecutive cycles with no duplicate.
- Flush in FULL: state FULL (PC 0x20 and 0x24 held) with flush_i=1 -> out_valid_o=0, ctrl_e_o=0, occupancy_o=0 and in_ready_o=1 next cycle. A subsequent PC 0x40 appears one cycle later.
- Flush with concurrent input: in_valid_i=1 (PC 0x50, ctrl 0x3FF) and flush_i=1 in the same cycle -> 0x50 is never presented and ctrl_e_o stays 0.
- Control-clear invariant: send ctrl 0x3FF then hold in_valid_i=0 with out_ready_i=1 -> after drain, out_valid_o=0 and ctrl_e_o=0x000, while pc_e_o holds its last value.
- Reset mid-stream: rst=1 while FULL with flush_i=1 -> all outputs zero and in_ready_o=1 next cycle.
